// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and the parity helper for the PS/2 key receiver.
package ps2_pkg;

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX   = 8'hE0;
    localparam int         FRAME_BITS   = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // PS/2 uses odd parity across the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings ps2_clk/ps2_data into the clk domain and flags each ps2_clk falling edge.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic sync_data,
    output logic fe
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   prev_clk;

    // Lines idle high, so the chains reset to 1 to avoid a phantom edge on release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            prev_clk  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            prev_clk  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign sync_data = data_sync[SYNC_STAGES-1];
    assign fe        = prev_clk & ~clk_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 frame deserialiser with make/break/extended decoding and single held-key tracking.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_in,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       make_pulse,
    output logic       break_pulse,
    output logic       extended,
    output logic       frame_error
);

    localparam int               WD_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    state_t          state_next;
    logic            sync_data;
    logic            fe;
    logic [2:0]      bitcnt;
    logic [7:0]      shreg;
    logic            parity_bit;
    logic [WD_W-1:0] wd;
    logic            break_pend;
    logic            ext_pend;
    logic            timeout;
    logic            start_bad;
    logic            frame_end;
    logic            frame_ok;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .sync_data (sync_data),
        .fe        (fe)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        timeout    = 1'b0;
        start_bad  = 1'b0;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                if (fe) begin
                    if (!sync_data) state_next = DATA;
                    else            start_bad  = 1'b1;
                end
            end
            DATA: begin
                if (fe && bitcnt == 3'd7) state_next = PARITY;
            end
            PARITY: begin
                if (fe) state_next = STOP;
            end
            STOP: begin
                if (fe) begin
                    frame_end  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // An edge landing on the terminal count wins over the watchdog.
        if (state != IDLE && !fe && wd == WD_MAX) begin
            timeout    = 1'b1;
            state_next = IDLE;
        end
    end

    assign frame_ok = frame_end && sync_data && odd_parity_ok(shreg, parity_bit);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitcnt         <= 3'd0;
            shreg          <= 8'h00;
            parity_bit     <= 1'b0;
            wd             <= '0;
            break_pend     <= 1'b0;
            ext_pend       <= 1'b0;
            key_in         <= 8'h00;
            scancode       <= 8'h00;
            scancode_valid <= 1'b0;
            make_pulse     <= 1'b0;
            break_pulse    <= 1'b0;
            extended       <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            scancode_valid <= 1'b0;
            make_pulse     <= 1'b0;
            break_pulse    <= 1'b0;
            frame_error    <= start_bad | timeout | (frame_end & ~frame_ok);

            if (state == IDLE || fe || timeout) wd <= '0;
            else                                wd <= wd + 1'b1;

            if (state == IDLE || timeout) begin
                bitcnt <= 3'd0;
            end else if (state == DATA && fe) begin
                shreg[bitcnt] <= sync_data;
                bitcnt        <= bitcnt + 3'd1;
            end

            if (state == PARITY && fe) parity_bit <= sync_data;

            if (frame_ok) begin
                scancode       <= shreg;
                scancode_valid <= 1'b1;
                if (shreg == EXT_PREFIX) begin
                    ext_pend <= 1'b1;
                end else if (shreg == BREAK_PREFIX) begin
                    break_pend <= 1'b1;
                end else if (break_pend) begin
                    break_pulse <= 1'b1;
                    extended    <= ext_pend;
                    if (key_in == shreg) key_in <= 8'h00;
                    break_pend  <= 1'b0;
                    ext_pend    <= 1'b0;
                end else begin
                    make_pulse <= 1'b1;
                    extended   <= ext_pend;
                    key_in     <= shreg;
                    ext_pend   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/ps2_key_receiver.md
Name: ps2_key_receiver

Overview:
- Upstream front end for game_mode. Deserialises PS/2 keyboard frames into scan-code bytes and tracks the currently held key.
- Drives the `key_in[7:0]` bus that the error checker compares against the expected scrolling scan code.
- Flags make, break and extended events, rejects corrupt frames, and resynchronises after a stalled frame.

Parameters:
- TIMEOUT_CYCLES, 50000: idle-clk cycles with no PS/2 falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).
- SYNC_STAGES, 2: flip-flop depth of the ps2_clk/ps2_data synchronisers; legal values are 2 or 3.

Ports:
- clk  in  1  system clock; everything in this block is clocked on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock line from the pin; asynchronous to clk.
- ps2_data  in  1  raw PS/2 data line from the pin; asynchronous to clk.
- key_in  out  8  make code of the currently held key; 8'h00 when no key is held. Connects to game_mode.key_in.
- scancode  out  8  last accepted data byte, prefixes included; held until the next accepted byte.
- scancode_valid  out  1  one-cycle pulse when scancode updates.
- make_pulse  out  1  one-cycle pulse when a non-prefix byte arrives without a pending break.
- break_pulse  out  1  one-cycle pulse when a non-prefix byte arrives after the F0 prefix.
- extended  out  1  level: the last make/break event was E0-prefixed.
- frame_error  out  1  one-cycle pulse on a bad start, parity, stop or timeout.

Behaviour:
- Reset (async assert, sync release): all outputs are 0, FSM goes to IDLE, bit counter is 0, break_pend=0, ext_pend=0.
- Synchronise ps2_clk and ps2_data through SYNC_STAGES flops. A falling edge (fe) is prev_sync_clk=1 and sync_clk=0, one clk cycle wide. Data is sampled from sync_data in the cycle fe is high.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fe, if data=0 go to DATA with bitcnt=0. If data=1, stay in IDLE and pulse frame_error.
  - DATA: on fe, shift the bit into shreg[bitcnt] (LSB first) and increment bitcnt. After bit 7, go to PARITY.
  - PARITY: on fe, store the bit and go to STOP.
  - STOP: on fe, evaluate the frame and return to IDLE.
- Frame acceptance: the frame is accepted only if stop=1 AND XOR(shreg, parity)=1 (odd parity). Otherwise pulse frame_error and discard the byte; break_pend and ext_pend are unchanged.
- Timeout: a watchdog counter runs in DATA, PARITY and STOP and clears on every fe. When it reaches TIMEOUT_CYCLES-1: go to IDLE, pulse frame_error, bitcnt=0. Its width is clog2(TIMEOUT_CYCLES).
- Latency: every output update happens in the cycle after the stop-bit fe cycle (registered). Pin-to-fe latency is SYNC_STAGES+1 clk cycles.
- Accepted byte B: set scancode=B and pulse scancode_valid, then:
  - B=8'hE0: ext_pend=1. No make or break pulse.
  - B=8'hF0: break_pend=1. No make or break pulse.
  - Otherwise, if break_pend: pulse break_pulse; extended=ext_pend; if key_in==B, key_in=0. Then clear both pending flags.
  - Otherwise: pulse make_pulse; extended=ext_pend; key_in=B (typematic repeats re-pulse make_pulse and leave key_in at B); clear ext_pend.
- Only one key is tracked. A new make code overwrites key_in. A break for a key that is not held leaves key_in unchanged.
- Simultaneous events:
  - fe arriving in the same cycle as the timeout terminal count: fe wins and the counter clears.
  - reset mid-frame: immediate abort; no pulses fire.
- Only one of the pulses scancode_valid, make_pulse, break_pulse and frame_error can fire per cycle, except that scancode_valid co-fires with make_pulse or break_pulse.

Decomposition:
- ps2_pkg holds: BREAK_PREFIX=8'hF0, EXT_PREFIX=8'hE0, the state encoding (IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3), and FRAME_BITS=11.
- One sub-module, ps2_sync_edge: parameterised synchroniser plus falling-edge detector. Outputs are sync_data and fe.

Test Plan:
- Send a valid frame for 8'h1C (A, parity=0, stop=1) → scancode=8'h1C, one scancode_valid and one make_pulse, key_in=8'h1C, extended=0, frame_error never asserted.
- Hold 1C, then send F0 then 1C → on the F0 byte only scancode_valid fires; on the 1C byte break_pulse fires and key_in returns to 8'h00.
- Send E0, 75 (up arrow) then E0, F0, 75 → first make_pulse with extended=1 and key_in=8'h75; then break_pulse with extended=1 and key_in=8'h00.
- Send 8'h1C with the parity bit flipped → one frame_error pulse; scancode, key_in and the pending flags unchanged; the next good frame is accepted.
- Send 4 data bits then stall ps2_clk high for TIMEOUT_CYCLES (set to 100 in the bench) → frame_error pulses at count 99, FSM is back in IDLE, and a following full frame decodes correctly.
- Assert reset low mid-frame after bit 5 → all outputs 0 immediately; after release, a fresh 8'h2B frame produces key_in=8'h2B.
